// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the riscv_core ROM program loader.
// Loader state encodings and word-packing geometry.
package rom_loader_pkg;

  localparam int ROM_WORD_W     = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_CHECK = 2'd3
  } load_state_e;

endpackage

// File: rtl/rom_loader_pack.sv
// Byte-to-word packer: places little-endian stream bytes into a 32-bit word.
// word_full flags the accept that completes the word; the index then wraps to 0.
module rom_loader_pack
  import rom_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            data,
  output logic                  word_full,
  output logic [ROM_WORD_W-1:0] word
);

  logic [BYTE_IDX_W-1:0] idx;

  assign word_full = accept && (idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (accept) begin
      word[{idx, 3'b000} +: 8] <= data;
      idx                      <= idx + BYTE_IDX_W'(1);
    end
  end

endmodule

// File: rtl/rom_loader.sv
// ROM program loader: streams bytes into ROM words and holds the core in reset
// until the image is loaded. Define ROM_LOADER_CHECKSUM_EN to require a trailer checksum byte.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ROM_AW = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_start_i,
  input  logic [ROM_AW:0]       load_len_i,
  input  logic                  byte_vld_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_rdy_o,
  output logic                  rom_we_o,
  output logic [ROM_AW-1:0]     rom_waddr_o,
  output logic [ROM_WORD_W-1:0] rom_wdata_o,
  output logic                  core_rstn_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [ROM_AW:0] DEPTH = (ROM_AW + 1)'(1) << ROM_AW;

  load_state_e       state, state_n;
  logic [ROM_AW:0]   word_cnt, word_cnt_n, cnt_inc, len_q, len_n;
  logic [ROM_AW-1:0] waddr_n;
  logic              rdy_n, we_n, crst_n, done_n, err_n;
  logic              accept, pack_accept, pack_clear, word_full;

  assign accept      = byte_vld_i && byte_rdy_o;
  assign pack_accept = accept && (state == ST_RECV);
  assign cnt_inc     = word_cnt + (ROM_AW + 1)'(1);

  rom_loader_pack u_pack (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (pack_clear),
    .accept    (pack_accept),
    .data      (byte_i),
    .word_full (word_full),
    .word      (rom_wdata_o)
  );

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, trailer_sum;

  assign trailer_sum = sum_q + byte_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             sum_q <= '0;
    else if (pack_clear)   sum_q <= '0;
    else if (pack_accept)  sum_q <= sum_q + byte_i;
  end
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n    = state;
    word_cnt_n = word_cnt;
    len_n      = len_q;
    waddr_n    = rom_waddr_o;
    rdy_n      = 1'b0;
    we_n       = 1'b0;
    crst_n     = core_rstn_o;
    done_n     = done_o;
    err_n      = err_o;
    pack_clear = 1'b0;

    case (state)
      ST_IDLE: begin
        if (load_start_i) begin
          done_n     = 1'b0;
          err_n      = 1'b0;
          crst_n     = 1'b0;
          word_cnt_n = '0;
          len_n      = load_len_i;
          pack_clear = 1'b1;
          if (load_len_i == '0) begin
            done_n = 1'b1;
            crst_n = 1'b1;
          end else if (load_len_i > DEPTH) begin
            err_n = 1'b1;
          end else begin
            state_n = ST_RECV;
            rdy_n   = 1'b1;
          end
        end
      end

      ST_RECV: begin
        rdy_n = 1'b1;
        if (pack_accept && word_full) begin
          state_n = ST_WRITE;
          rdy_n   = 1'b0;
          we_n    = 1'b1;
          waddr_n = word_cnt[ROM_AW-1:0];
        end
      end

      ST_WRITE: begin
        word_cnt_n = cnt_inc;
        if (cnt_inc == len_q) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_n = ST_CHECK;
          rdy_n   = 1'b1;
`else
          state_n = ST_IDLE;
          done_n  = 1'b1;
          crst_n  = 1'b1;
`endif
        end else begin
          state_n = ST_RECV;
          rdy_n   = 1'b1;
        end
      end

`ifdef ROM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        rdy_n = 1'b1;
        if (accept) begin
          rdy_n   = 1'b0;
          state_n = ST_IDLE;
          if (trailer_sum == 8'd0) begin
            done_n = 1'b1;
            crst_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
`endif

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      word_cnt    <= '0;
      len_q       <= '0;
      byte_rdy_o  <= 1'b0;
      rom_we_o    <= 1'b0;
      rom_waddr_o <= '0;
      core_rstn_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_n;
      word_cnt    <= word_cnt_n;
      len_q       <= len_n;
      byte_rdy_o  <= rdy_n;
      rom_we_o    <= we_n;
      rom_waddr_o <= waddr_n;
      core_rstn_o <= crst_n;
      busy_o      <= (state_n != ST_IDLE);
      done_o      <= done_n;
      err_o       <= err_n;
    end
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Hardware program loader for the riscv_core instruction ROM. It accepts a byte stream over a valid/ready handshake and packs little-endian bytes into 32-bit instruction words. It writes each word through the ROM write port and holds the core in reset until the image is fully loaded. It sits between the host/debug link and `u_rom`, and replaces file-based preloading of ROM contents for hardware bring-up.

## Interface
- `ROM_AW`, 12, ROM word-address width; depth = 2^ROM_AW words
- `clk`  in  1  system clock, rising-edge
- `rstn`  in  1  asynchronous, active-low reset
- `load_start_i`  in  1  single-cycle request to begin a load; sampled only in IDLE
- `load_len_i`  in  ROM_AW+1  number of 32-bit words to load; sampled with `load_start_i`
- `byte_vld_i`  in  1  stream byte valid
- `byte_i`  in  8  stream byte
- `byte_rdy_o`  out  1  loader can accept a byte
- `rom_we_o`  out  1  ROM write strobe, one cycle per word
- `rom_waddr_o`  out  ROM_AW  ROM word address
- `rom_wdata_o`  out  32  ROM write data
- `core_rstn_o`  out  1  active-low reset to riscv_core; low while not loaded
- `busy_o`  out  1  load in progress
- `done_o`  out  1  sticky: last load completed successfully
- `err_o`  out  1  sticky: last load rejected or failed

## Operation
- States:
  - IDLE
  - RECV: collecting the 4 bytes of a word
  - WRITE: one-cycle ROM write
  - CHECK: checksum; present only with the macro
- Byte transfer occurs on a rising edge with `byte_vld_i && byte_rdy_o`. `byte_rdy_o` = 1 only in RECV (and in CHECK).
- IDLE + `load_start_i`:
  - clears `done_o` and `err_o`
  - drives `core_rstn_o` low
  - clears the word counter and byte index
  - if `load_len_i` == 0: sets `done_o`, releases `core_rstn_o`, stays in IDLE
  - if `load_len_i` > 2^ROM_AW: sets `err_o`, keeps `core_rstn_o` low, stays in IDLE
  - otherwise: goes to RECV
- RECV: byte k (0..3) lands in `rom_wdata_o[8k+7:8k]`. The 4th accepted byte moves the FSM to WRITE.
- WRITE:
  - `rom_we_o` = 1, `rom_waddr_o` = word counter, then the counter increments
  - if the counter reaches `load_len_i`, go to IDLE with `done_o` = 1 and `core_rstn_o` = 1 (or to CHECK if the macro is defined)
  - otherwise return to RECV
- `load_start_i` outside IDLE is ignored. Bytes offered in IDLE or WRITE are not consumed.
- `busy_o` = (state != IDLE).
- Word-counter and address arithmetic is unsigned. Addresses wrap never occur because the length is bounded to the depth.

## Timing
- Reset values:
  - state IDLE
  - `byte_rdy_o` 0
  - `rom_we_o` 0
  - `rom_waddr_o` 0
  - `rom_wdata_o` 0
  - `core_rstn_o` 0
  - `busy_o` 0
  - `done_o` 0
  - `err_o` 0
- Start accepted at edge E → `busy_o` and `byte_rdy_o` high from E (registered outputs).
- 4th byte accepted at edge N → `rom_we_o` high for exactly the cycle between N and N+1 → `byte_rdy_o` high again after N+1. Peak throughput is 4 bytes per 5 cycles.
- Last WRITE at edge N+1 → `done_o` and `core_rstn_o` high after N+1 (without the macro).
- All outputs are registered; there is no combinational path from `byte_vld_i` to `byte_rdy_o`.
- `rstn` asserted mid-load: everything returns to reset values immediately. The partial ROM image is left as written; the core stays in reset.

## Configuration
- `ROM_LOADER_CHECKSUM_EN` defined:
  - an 8-bit running sum of all data bytes is kept
  - after the last WRITE, the FSM enters CHECK and accepts one trailer byte
  - if (sum + trailer) mod 256 == 0: `done_o` = 1 and `core_rstn_o` = 1
  - otherwise: `err_o` = 1 and `core_rstn_o` stays 0
  - either way the FSM returns to IDLE
- Undefined: no CHECK state, no trailer byte, no sum register; completion occurs directly after the last WRITE.

## Structure
- Shared defines header (alongside the core's existing `define` set): loader state encodings, `ROM_WORD_W` = 32, and the byte-per-word count 4.
- One sub-module, `rom_loader_pack`: byte index counter plus shift/insert into the 32-bit word. It asserts `word_full` on the 4th byte and clears on WRITE.
- Top `rom_loader`: FSM, word counter, length check, checksum, output flags.

## Test plan
- Reset mid-load: assert `rstn` after 5 bytes → all outputs return to reset values; a subsequent load of 1 word completes normally.
- Load len 2, bytes 13 00 00 00 93 00 10 00 (vld held high) → writes (addr 0, 0x00000013) then (addr 1, 0x00100093). Each `rom_we_o` lasts 1 cycle; `done_o` = 1 and `core_rstn_o` = 1 after the 2nd write.
- Backpressure/gaps: drop `byte_vld_i` randomly during len 3 → same data at addresses 0..2. No byte is consumed during WRITE.
- Length edges:
  - `load_len_i` = 0 → `done_o` = 1 immediately, with no writes
  - `load_len_i` = 2^ROM_AW + 1 → `err_o` = 1, `core_rstn_o` stays 0
- `load_start_i` pulsed while busy → ignored; the counter and address sequence are unchanged.
- With `ROM_LOADER_CHECKSUM_EN`, len 1, bytes 01 02 03 04:
  - trailer 0xF6 → `done_o` = 1
  - trailer 0xF7 → `err_o` = 1 and `core_rstn_o` = 0
